// File: rtl/alu_arbiter_if.sv
// Request/response bundle between two ALU requesters, the arbiter and the
// result consumer. master = requester/consumer side, slave = arbiter side.
interface alu_arbiter_if #(
    parameter int WIDTH = 4
);
    logic             req0, req1;
    logic [WIDTH-1:0] a0, b0, a1, b1;
    logic [1:0]       op0, op1;
    logic             cin0, cin1;
    logic             ack0, ack1;
    logic [WIDTH-1:0] res;
    logic             cout;
    logic             res_valid;
    logic             res_id;
    logic             res_ready;

    modport master (
        output req0, req1, a0, b0, a1, b1, op0, op1, cin0, cin1, res_ready,
        input  ack0, ack1, res, cout, res_valid, res_id
    );

    modport slave (
        input  req0, req1, a0, b0, a1, b1, op0, op1, cin0, cin1, res_ready,
        output ack0, ack1, res, cout, res_valid, res_id
    );
endinterface

// File: rtl/alu_arbiter.sv
// Two-requester arbiter in front of a single shared ALU.
// IDLE grants and captures operands (ack pulses in that cycle), EXEC computes
// and registers the result, DONE holds it until the consumer takes it.
// Optional macro ALU_ARB_FIXED_PRI_EN: requester 0 always wins contention;
// otherwise round-robin on a last-grant pointer.
module alu_arbiter #(
    parameter int WIDTH = 4
) (
    input logic         clk,
    input logic         rst_n,
    alu_arbiter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

    state_t           state, state_nxt;
    logic             grant_any, grant_id;
    logic [WIDTH-1:0] a_q, b_q;
    logic [1:0]       op_q;
    logic             cin_q, id_q;
    logic [WIDTH:0]   alu_out;

    assign grant_any = bus.req0 | bus.req1;

`ifdef ALU_ARB_FIXED_PRI_EN
    // Fixed priority: requester 1 only when requester 0 is not asking
    always_comb grant_id = ~bus.req0;
`else
    logic last_grant;  // 1 = requester 1 was granted last

    // Round-robin: on contention pick the one not granted last
    always_comb grant_id = (bus.req0 & bus.req1) ? ~last_grant : bus.req1;

    // Track the most recent grant for the next contention
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            last_grant <= 1'b1;
        else if (state == IDLE && grant_any)
            last_grant <= grant_id;
    end
`endif

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (grant_any) state_nxt = EXEC;
            EXEC:    state_nxt = DONE;
            DONE:    if (bus.res_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Outputs decoded from state; ack gated by reset so it is low while held
    always_comb begin
        bus.ack0      = rst_n && state == IDLE && grant_any && !grant_id;
        bus.ack1      = rst_n && state == IDLE && grant_any &&  grant_id;
        bus.res_valid = (state == DONE);
    end

    // ALU on the captured operands, WIDTH+1 bits so the top bit is carry/borrow
    always_comb begin
        alu_out = '0;
        case (op_q)
            2'b00: alu_out = {1'b0, a_q & b_q};
            2'b01: alu_out = {1'b0, a_q} + {1'b0, b_q} + {{WIDTH{1'b0}}, cin_q};
            2'b10: alu_out = {1'b0, a_q} - {1'b0, b_q};
            default: alu_out = {1'b0, a_q ^ b_q};
        endcase
    end

    // Operand capture on grant, result register on EXEC
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q        <= '0;
            b_q        <= '0;
            op_q       <= '0;
            cin_q      <= 1'b0;
            id_q       <= 1'b0;
            bus.res    <= '0;
            bus.cout   <= 1'b0;
            bus.res_id <= 1'b0;
        end else begin
            if (state == IDLE && grant_any) begin
                a_q   <= grant_id ? bus.a1   : bus.a0;
                b_q   <= grant_id ? bus.b1   : bus.b0;
                op_q  <= grant_id ? bus.op1  : bus.op0;
                cin_q <= grant_id ? bus.cin1 : bus.cin0;
                id_q  <= grant_id;
            end
            if (state == EXEC) begin
                bus.res    <= alu_out[WIDTH-1:0];
                bus.cout   <= alu_out[WIDTH];
                bus.res_id <= id_q;
            end
        end
    end
endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: single operations, wrap/borrow, contention,
// back-pressure and reset during execution.
module tb_alu_arbiter;
    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_fail;

    alu_arbiter_if #(.WIDTH(4)) bus ();

    alu_arbiter #(.WIDTH(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        bus.req0 = 1'b1;
        bus.req1 = 1'b1;
        #1;
        n_checks++;
        if (bus.ack0 !== 1'b0 || bus.ack1 !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_ack: got %b%b expected 00", bus.ack0, bus.ack1);
        end
        n_checks++;
        if ({bus.res_valid, bus.res, bus.cout, bus.res_id} !== 7'b0) begin
            n_fail++;
            $display("FAIL reset_outs: got v=%b res=%h c=%b id=%b expected all 0",
                     bus.res_valid, bus.res, bus.cout, bus.res_id);
        end
        bus.req0 = 1'b0;
        bus.req1 = 1'b0;
        step();
        rst_n = 1'b1;
        step();
    endtask

    // One operation with res_ready high; operands are scrambled after ack
    task automatic run_single(input bit id, input logic [3:0] a, input logic [3:0] b,
                              input logic [1:0] op, input bit cin,
                              input logic [3:0] er, input bit ec, input string nm);
        bus.res_ready = 1'b1;
        if (id) begin
            bus.req1 = 1'b1; bus.a1 = a; bus.b1 = b; bus.op1 = op; bus.cin1 = cin;
        end else begin
            bus.req0 = 1'b1; bus.a0 = a; bus.b0 = b; bus.op0 = op; bus.cin0 = cin;
        end
        #1;
        n_checks++;
        if (bus.ack0 !== !id || bus.ack1 !== id) begin
            n_fail++;
            $display("FAIL %s_ack: got ack0=%b ack1=%b expected id %0d", nm, bus.ack0, bus.ack1, id);
        end
        step();
        bus.req0 = 1'b0; bus.req1 = 1'b0;
        bus.a0 = ~a; bus.b0 = ~b; bus.op0 = op ^ 2'b11; bus.cin0 = ~cin;
        bus.a1 = ~a; bus.b1 = ~b; bus.op1 = op ^ 2'b11; bus.cin1 = ~cin;
        #1;
        n_checks++;
        if (bus.ack0 !== 1'b0 || bus.ack1 !== 1'b0 || bus.res_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL %s_exec: got ack=%b%b valid=%b expected 0", nm, bus.ack0, bus.ack1, bus.res_valid);
        end
        step();
        n_checks++;
        if (bus.res_valid !== 1'b1 || bus.res !== er || bus.cout !== ec || bus.res_id !== id) begin
            n_fail++;
            $display("FAIL %s_result: got v=%b res=%h c=%b id=%b expected v=1 res=%h c=%b id=%b",
                     nm, bus.res_valid, bus.res, bus.cout, bus.res_id, er, ec, id);
        end
        step();
        n_checks++;
        if (bus.res_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL %s_release: got valid=%b expected 0", nm, bus.res_valid);
        end
    endtask

    task automatic test_add;
        run_single(1'b0, 4'h3, 4'h4, 2'b01, 1'b1, 4'h8, 1'b0, "add");
    endtask

    task automatic test_sub;
        run_single(1'b1, 4'h2, 4'h5, 2'b10, 1'b0, 4'hD, 1'b1, "sub");
    endtask

    task automatic test_wrap;
        run_single(1'b0, 4'hF, 4'h1, 2'b01, 1'b0, 4'h0, 1'b1, "wrap");
    endtask

    task automatic test_backpressure;
        bus.res_ready = 1'b0;
        bus.req0 = 1'b1; bus.a0 = 4'hC; bus.b0 = 4'hA; bus.op0 = 2'b00; bus.cin0 = 1'b1;
        #1;
        n_checks++;
        if (bus.ack0 !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_ack0: got %b expected 1", bus.ack0);
        end
        step();
        bus.req0 = 1'b0;
        bus.req1 = 1'b1; bus.a1 = 4'h5; bus.b1 = 4'h3; bus.op1 = 2'b11; bus.cin1 = 1'b1;
        #1;
        n_checks++;
        if (bus.ack1 !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_exec_ack1: got %b expected 0", bus.ack1);
        end
        step();
        for (int i = 0; i < 5; i++) begin
            n_checks++;
            if (bus.res_valid !== 1'b1 || bus.res !== 4'h8 || bus.cout !== 1'b0 || bus.ack1 !== 1'b0) begin
                n_fail++;
                $display("FAIL bp_hold%0d: got v=%b res=%h c=%b ack1=%b expected v=1 res=8 c=0 ack1=0",
                         i, bus.res_valid, bus.res, bus.cout, bus.ack1);
            end
            step();
        end
        bus.res_ready = 1'b1;
        #1;
        n_checks++;
        if (bus.res_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_accept_cycle: got valid=%b expected 1", bus.res_valid);
        end
        step();
        n_checks++;
        if (bus.res_valid !== 1'b0 || bus.ack1 !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_after_accept: got valid=%b ack1=%b expected valid=0 ack1=1", bus.res_valid, bus.ack1);
        end
        step();
        bus.req1 = 1'b0;
        step();
        n_checks++;
        if (bus.res_valid !== 1'b1 || bus.res !== 4'h6 || bus.cout !== 1'b0 || bus.res_id !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_xor: got v=%b res=%h c=%b id=%b expected v=1 res=6 c=0 id=1",
                     bus.res_valid, bus.res, bus.cout, bus.res_id);
        end
        step();
    endtask

    task automatic test_round_robin;
        logic [3:0] exp_ids;
        logic [3:0] got_ids;
        int         ack_cyc [4];
        int         n_acks;
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        step();
`ifdef ALU_ARB_FIXED_PRI_EN
        exp_ids = 4'b0000;
`else
        exp_ids = 4'b1010;  // bit k = id of k-th grant: 0,1,0,1
`endif
        got_ids = '0;
        n_acks  = 0;
        bus.res_ready = 1'b1;
        bus.req0 = 1'b1; bus.a0 = 4'h1; bus.b0 = 4'h1; bus.op0 = 2'b01; bus.cin0 = 1'b0;
        bus.req1 = 1'b1; bus.a1 = 4'h7; bus.b1 = 4'h2; bus.op1 = 2'b10; bus.cin1 = 1'b0;
        for (int c = 0; c < 20 && n_acks < 4; c++) begin
            #1;
            n_checks++;
            if (bus.ack0 === 1'b1 && bus.ack1 === 1'b1) begin
                n_fail++;
                $display("FAIL rr_both_ack: cycle %0d got ack0=ack1=1 expected at most one", c);
            end
            if (bus.ack0 === 1'b1 || bus.ack1 === 1'b1) begin
                got_ids[n_acks] = bus.ack1;
                ack_cyc[n_acks] = c;
                n_acks++;
            end
            step();
        end
        bus.req0 = 1'b0;
        bus.req1 = 1'b0;
        n_checks++;
        if (n_acks != 4 || got_ids !== exp_ids) begin
            n_fail++;
            $display("FAIL rr_order: got %0d acks ids=%b expected 4 acks ids=%b", n_acks, got_ids, exp_ids);
        end
        for (int k = 1; k < n_acks; k++) begin
            n_checks++;
            if (ack_cyc[k] - ack_cyc[k-1] != 3) begin
                n_fail++;
                $display("FAIL rr_spacing%0d: got %0d cycles expected 3", k, ack_cyc[k] - ack_cyc[k-1]);
            end
        end
        step();
        step();
        step();
    endtask

    task automatic test_reset_mid;
        bus.res_ready = 1'b1;
        bus.req1 = 1'b1; bus.a1 = 4'h5; bus.b1 = 4'h3; bus.op1 = 2'b11; bus.cin1 = 1'b0;
        step();
        bus.req1 = 1'b0;
        step();
        step();
        bus.req0 = 1'b1; bus.a0 = 4'h9; bus.b0 = 4'h9; bus.op0 = 2'b01; bus.cin0 = 1'b0;
        step();
        bus.req0 = 1'b0;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({bus.res_valid, bus.res, bus.cout, bus.res_id, bus.ack0, bus.ack1} !== 9'b0) begin
            n_fail++;
            $display("FAIL rstmid_outs: got v=%b res=%h c=%b id=%b ack=%b%b expected all 0",
                     bus.res_valid, bus.res, bus.cout, bus.res_id, bus.ack0, bus.ack1);
        end
        step();
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            n_checks++;
            if (bus.res_valid !== 1'b0 || bus.res !== 4'h0) begin
                n_fail++;
                $display("FAIL rstmid_no_result%0d: got v=%b res=%h expected v=0 res=0", i, bus.res_valid, bus.res);
            end
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst_n    = 1'b0;
        bus.req0 = 1'b0; bus.req1 = 1'b0;
        bus.a0 = '0; bus.b0 = '0; bus.a1 = '0; bus.b1 = '0;
        bus.op0 = '0; bus.op1 = '0; bus.cin0 = 1'b0; bus.cin1 = 1'b0;
        bus.res_ready = 1'b1;
        @(negedge clk);
        test_reset();
        test_add();
        test_sub();
        test_wrap();
        test_backpressure();
        test_round_robin();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter: WIDTH, 4, operand/result width in bits.
REQ-002 clk  input  1  rising-edge clock.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 req0, req1  input  1 each  requester n wants one ALU operation; held high until its ack.
REQ-005 a0, b0, a1, b1  input  WIDTH each  operands of requester 0/1.
REQ-006 op0, op1  input  2 each  opcode: 00 A&B, 01 A+B+cin, 10 A-B, 11 A^B.
REQ-007 cin0, cin1  input  1 each  carry-in, used only by opcode 01.
REQ-008 ack0, ack1  output  1 each  one-cycle pulse: operands of requester n captured.
REQ-009 res  output  WIDTH  registered result.
REQ-010 cout  output  1  registered carry/borrow; 0 for opcodes 00 and 11.
REQ-011 res_valid  output  1  res/cout/res_id valid.
REQ-012 res_id  output  1  requester that owns res.
REQ-013 res_ready  input  1  consumer accepts result when res_valid and res_ready are both high.

Function
REQ-014 The FSM SHALL have states IDLE, EXEC and DONE.
REQ-015 IDLE: if any req high, grant per REQ-019, latch that requester's a, b, op, cin, pulse its ack for exactly that cycle, go EXEC; else stay.
REQ-016 EXEC: compute {cout,res} from latched operands, set res_id, go DONE; res_valid rises the cycle DONE is entered.
REQ-017 DONE: hold res, cout, res_id, res_valid=1 while res_ready low; on res_ready high, clear res_valid and return to IDLE.
REQ-018 Latency: ack to res_valid SHALL be exactly 2 cycles; minimum spacing between two acks is 3 cycles.
REQ-019 Round-robin: when both req high in IDLE, grant the requester not granted last; single req is granted immediately.
REQ-020 Arithmetic: opcode 01 {cout,res} = A+B+cin in WIDTH+1 bits; opcode 10 {cout,res} = A-B in WIDTH+1 bits (cout=1 means borrow); opcodes 00/11 cout=0.
REQ-021 Inputs changing after ack SHALL not affect the in-flight result.
REQ-022 ack0 and ack1 SHALL never be high in the same cycle; neither is asserted outside IDLE.
REQ-023 A req dropped before ack SHALL be treated as withdrawn, no operation performed.

Reset
REQ-024 rst_n low SHALL, asynchronously, force state IDLE, res=0, cout=0, res_valid=0, res_id=0, ack0=ack1=0, last-grant pointer=1 (requester 0 wins first contention).
REQ-025 Reset mid-operation SHALL discard the in-flight operation without a result.

Configuration
REQ-026 Macro ALU_ARB_FIXED_PRI_EN defined: requester 0 always wins contention, last-grant pointer removed; undefined: round-robin per REQ-019.

Verification
REQ-027 Reset then req0, a0=3, b0=4, op0=01, cin0=1, res_ready=1 -> ack0 at cycle 1, res_valid at cycle 3, res=8, cout=0, res_id=0.
REQ-028 req1, a1=2, b1=5, op1=10 -> res=4'hD, cout=1, res_id=1.
REQ-029 req0, a0=F, b0=1, op0=01, cin0=0 -> res=0, cout=1 (wrap-around).
REQ-030 req0 and req1 held high continuously, res_ready=1 -> acks alternate 0,1,0,1; with ALU_ARB_FIXED_PRI_EN -> ack0 only.
REQ-031 res_ready low 5 cycles in DONE -> res/res_valid stable, no ack; res_ready high -> res_valid low next cycle, next ack one cycle later.
REQ-032 rst_n low during EXEC -> all outputs 0 immediately, no res_valid after release.
